// File: rtl/spike_shift_pipe.sv
// Two-stage valid/ready pipeline that shifts per-channel temporal spike vectors
// by a one-hot signed amount, with drop / wrap / saturate edge handling.
module spike_shift_pipe #(
  parameter int NUM_CH        = 4,
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int CNT_W         = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_CH*LEN-1:0]                  in_spikes,
  input  logic [NUM_CH*(2*MAX_SHIFT_MAG+1)-1:0]  in_shift,
  input  logic [1:0]                             mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_CH*LEN-1:0]                  out_spikes,
  output logic [NUM_CH-1:0]                      out_err,
  output logic [CNT_W-1:0]                       err_cnt
);

  localparam int SW = 2*MAX_SHIFT_MAG + 1;
  localparam int MW = $clog2(MAX_SHIFT_MAG + 1);
  localparam int EW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    MODE_DROP = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Stage 1 holds the shift as magnitude + direction so stage 2 only needs plain shifters.
  logic                         s1_valid;
  logic [NUM_CH*LEN-1:0]        s1_spikes;
  logic [NUM_CH-1:0][MW-1:0]    s1_mag;
  logic [NUM_CH-1:0]            s1_neg;
  logic [NUM_CH-1:0]            s1_err;
  mode_t                        s1_mode;

  logic                         s2_free;
  logic                         s1_load;
  logic                         s2_load;

  logic [NUM_CH-1:0][MW-1:0]    dec_mag;
  logic [NUM_CH-1:0]            dec_neg;
  logic [NUM_CH-1:0]            dec_err;
  logic [EW-1:0]                dec_nerr;
  logic [CNT_W:0]               cnt_sum;

  logic [NUM_CH*LEN-1:0]        shifted;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;

  always_comb begin
    logic [SW-1:0] f;
    int unsigned   ones;
    dec_mag  = '0;
    dec_neg  = '0;
    dec_err  = '0;
    dec_nerr = '0;
    f        = '0;
    ones     = 0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      f    = in_shift[c*SW +: SW];
      ones = 0;
      for (int unsigned i = 0; i < SW; i++) begin
        if (f[i]) begin
          ones++;
          if (i < MAX_SHIFT_MAG) begin
            dec_neg[c] = 1'b1;
            dec_mag[c] = MW'(MAX_SHIFT_MAG - i);
          end else begin
            dec_neg[c] = 1'b0;
            dec_mag[c] = MW'(i - MAX_SHIFT_MAG);
          end
        end
      end
      if (ones != 1) begin
        dec_neg[c] = 1'b0;
        dec_mag[c] = '0;
      end
      dec_err[c] = (ones > 1);
      dec_nerr   = dec_nerr + EW'(dec_err[c]);
    end
  end

  assign cnt_sum = {1'b0, err_cnt} + (CNT_W+1)'(dec_nerr);

  function automatic logic [LEN-1:0] shift_ch(
    input logic [LEN-1:0] v,
    input logic [MW-1:0]  mag,
    input logic           neg,
    input mode_t          md
  );
    logic [LEN-1:0] r;
    logic [LEN-1:0] lost;
    int unsigned    amt;
    int unsigned    ramt;
    amt  = 32'(mag);
    ramt = LEN - amt;
    r    = neg ? (v >> amt) : (v << amt);
    // Bits shifted out land at the far end of a reversed shift by LEN-amt.
    lost = neg ? (v << ramt) : (v >> ramt);
    case (md)
      MODE_WRAP: r = neg ? ((v >> amt) | (v << ramt)) : ((v << amt) | (v >> ramt));
      MODE_SAT: begin
        if (amt != 0 && lost != '0) begin
          if (neg) r[0] = 1'b1;
          else     r[LEN-1] = 1'b1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      shifted[c*LEN +: LEN] = shift_ch(s1_spikes[c*LEN +: LEN], s1_mag[c], s1_neg[c], s1_mode);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_spikes <= '0;
      out_err    <= '0;
      err_cnt    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        err_cnt  <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid  <= 1'b1;
        out_spikes <= shifted;
        out_err    <= s1_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (s1_load) begin
      s1_spikes <= in_spikes;
      s1_mag    <= dec_mag;
      s1_neg    <= dec_neg;
      s1_err    <= dec_err;
      s1_mode   <= mode_t'(mode);
    end
  end

endmodule

// File: tb/tb_spike_shift_pipe.sv
// Directed checks of spike_shift_pipe: shift modes, malformed fields, streaming with stalls, reset.
module tb_spike_shift_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_spikes;
  logic [19:0] in_shift;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_spikes;
  logic [3:0]  out_err;
  logic [15:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  spike_shift_pipe #(.NUM_CH(4), .LEN(8), .MAX_SHIFT_MAG(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .in_shift(in_shift), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_spikes = '0; in_shift = '0; mode = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    n_vec++; if (out_spikes !== 32'd0 || out_err !== 4'd0) begin
      n_err++; $display("FAIL reset_out_data got %h/%b want 0/0", out_spikes, out_err); end
  endtask

  task automatic run_vec(input string name, input logic [31:0] spk, input logic [19:0] sh,
                         input logic [1:0] md, input logic [31:0] exp_s, input logic [3:0] exp_e);
    int cyc;
    @(negedge clock);
    in_valid = 1'b1; in_spikes = spk; in_shift = sh; mode = md; out_ready = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
    @(negedge clock);
    // mode is changed right after acceptance; the captured value must be used
    in_valid = 1'b0; in_spikes = '0; in_shift = '0; mode = ~md;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 6) begin
      @(negedge clock);
      cyc++;
    end
    n_vec++; if (cyc != 2) begin n_err++; $display("FAIL %s_latency got %0d want 2", name, cyc); end
    n_vec++; if (out_spikes !== exp_s) begin n_err++; $display("FAIL %s_spikes got %h want %h", name, out_spikes, exp_s); end
    n_vec++; if (out_err !== exp_e) begin n_err++; $display("FAIL %s_err got %b want %b", name, out_err, exp_e); end
    @(negedge clock);
  endtask

  task automatic test_basic;
    run_vec("t1_drop_p1", 32'h0000_0002, 20'h00008, 2'b00, 32'h0000_0004, 4'b0000);
  endtask

  task automatic test_modes_pos;
    run_vec("t2_drop", 32'h0100_0081, 20'h10010, 2'b00, 32'h0000_0004, 4'b0000);
    run_vec("t2_wrap", 32'h0100_0081, 20'h10010, 2'b01, 32'h8000_0006, 4'b0000);
    run_vec("t2_sat",  32'h0100_0081, 20'h10010, 2'b10, 32'h0100_0084, 4'b0000);
    run_vec("t2_rsvd", 32'h0100_0081, 20'h10010, 2'b11, 32'h0000_0004, 4'b0000);
  endtask

  task automatic test_modes_neg;
    run_vec("t3_drop", 32'h0000_A503, 20'h00081, 2'b00, 32'h0000_A500, 4'b0000);
    run_vec("t3_wrap", 32'h0000_A503, 20'h00081, 2'b01, 32'h0000_A5C0, 4'b0000);
    run_vec("t3_sat",  32'h0000_A503, 20'h00081, 2'b10, 32'h0000_A501, 4'b0000);
  endtask

  task automatic test_malformed;
    run_vec("t4_one", 32'h005A_013C, 20'h02900, 2'b00, 32'h005A_023C, 4'b0100);
    n_vec++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL t4_err_cnt1 got %0d want 1", err_cnt); end
    run_vec("t4_two", 32'hC300_0081, 20'h1801F, 2'b01, 32'hC300_0081, 4'b1001);
    n_vec++; if (err_cnt !== 16'd3) begin n_err++; $display("FAIL t4_err_cnt3 got %0d want 3", err_cnt); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_q [10];
    int acc, del, cyc, occ;
    logic prev_stall, do_in, do_out;
    logic [31:0] prev_spk;
    for (int i = 0; i < 10; i++) exp_q[i] = {16'h0, 8'(i*7+1), 8'((i+1)*2)};
    acc = 0; del = 0; cyc = 0; occ = 0; prev_stall = 1'b0; prev_spk = '0;
    while (del < 10 && cyc < 300) begin
      @(negedge clock);
      out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (acc < 10);
      in_spikes = {16'h0, 8'(acc*7+1), 8'(acc+1)};
      in_shift  = 20'h00008;
      mode      = 2'b00;
      #1;
      if (prev_stall) begin
        n_vec++; if (out_valid !== 1'b1 || out_spikes !== prev_spk) begin
          n_err++; $display("FAIL t5_hold got %b/%h want 1/%h", out_valid, out_spikes, prev_spk); end
      end
      n_vec++; if (in_ready !== !(occ == 2 && !out_ready)) begin
        n_err++; $display("FAIL t5_in_ready got %b want %b (occ %0d)", in_ready, !(occ == 2 && !out_ready), occ); end
      do_out = out_valid && out_ready;
      do_in  = in_valid && in_ready;
      if (do_out) begin
        n_vec++; if (out_spikes !== exp_q[del]) begin
          n_err++; $display("FAIL t5_order[%0d] got %h want %h", del, out_spikes, exp_q[del]); end
        del++;
      end
      prev_stall = out_valid && !out_ready;
      prev_spk   = out_spikes;
      occ = occ + int'(do_in) - int'(do_out);
      acc = acc + int'(do_in);
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++; if (del != 10) begin n_err++; $display("FAIL t5_timeout got %0d outputs want 10", del); end
  endtask

  task automatic test_reset_stall;
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_spikes = 32'h0000_00FF; in_shift = 20'h00003; mode = 2'b00;
    repeat (2) @(negedge clock);
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL t6_full got in_ready %b out_valid %b want 0 1", in_ready, out_valid); end
    n_vec++; if (err_cnt !== 16'd5) begin n_err++; $display("FAIL t6_err_cnt got %0d want 5", err_cnt); end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t6_out_valid got %b want 0", out_valid); end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL t6_err_cnt0 got %0d want 0", err_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t6_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_spikes !== 32'd0 || out_err !== 4'd0) begin
      n_err++; $display("FAIL t6_out_data got %h/%b want 0/0", out_spikes, out_err); end
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t6_discard got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes_pos();
    test_modes_neg();
    test_malformed();
    test_stream();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
